// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// Holds the FSM state encoding and the prescale clamp.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  localparam int UART_MIN_PRESCALE = 4;
  localparam int UART_DATA_BITS    = 8;

  function automatic logic [15:0] clamp_prescale(
    input logic [15:0] v
  );
    if (v < 16'(UART_MIN_PRESCALE))
      return 16'(UART_MIN_PRESCALE);
    return v;
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI-Stream bundle with source and sink views.
// Valid/ready handshake, byte keep and last.
interface taxi_axis_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1
) ();

  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport src (
    output tdata, tkeep, tvalid, tlast,
    input  tready
  );

  modport snk (
    input  tdata, tkeep, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input.
// Both flops reset to RST_VAL.
module uart_rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // metastability filter: d -> meta -> q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_idle.sv
// UART byte receiver with AXI-Stream output and
// end-of-burst idle pulse after a quiet line.
module uart_rx_idle
  import uart_rx_pkg::*;
#(
  parameter int IDLE_BITS = 10,
  parameter int CNT_W     = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic [15:0] prescale,
  taxi_axis_if.src    m_axis,
  output logic        idle,
  output logic        busy,
  output logic        frame_error,
  output logic        overrun_error
);

  uart_rx_state_t state, state_n;

  logic             rxd_s;
  logic [15:0]      cnt, cnt_n;
  logic [15:0]      p, p_n;
  logic [15:0]      pc;
  logic [2:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic             brk, brk_n;
  logic             good, ferr, load;
  logic             tvalid;
  logic [7:0]       tdata;
  logic             armed;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] thr;

  uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rxd),
    .q     (rxd_s)
  );

  assign pc   = clamp_prescale(prescale);
  assign thr  = CNT_W'(IDLE_BITS) * CNT_W'(p);
  assign busy = (state != IDLE);
  assign load = good && !(tvalid && !m_axis.tready);

  assign m_axis.tvalid = tvalid;
  assign m_axis.tdata  = tdata;
  assign m_axis.tkeep  = 1'b1;
  assign m_axis.tlast  = 1'b0;

  // frame FSM and bit-timing registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      p     <= 16'(UART_MIN_PRESCALE);
      idx   <= '0;
      sh    <= '0;
      brk   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      p     <= p_n;
      idx   <= idx_n;
      sh    <= sh_n;
      brk   <= brk_n;
    end
  end

  // next state: sample on counter expiry, brk blocks
  // restart until the line recovers after a bad stop
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    p_n     = p;
    idx_n   = idx;
    sh_n    = sh;
    brk_n   = brk;
    good    = 1'b0;
    ferr    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rxd_s) begin
          brk_n = 1'b0;
        end else if (!brk) begin
          state_n = START;
          p_n     = pc;
          cnt_n   = pc >> 1;
        end
      end
      START: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else if (rxd_s) begin
          state_n = IDLE;
        end else begin
          state_n = DATA;
          cnt_n   = p - 16'd1;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          sh_n  = {rxd_s, sh[7:1]};
          cnt_n = p - 16'd1;
          idx_n = idx + 3'd1;
          if (idx == 3'(UART_DATA_BITS - 1))
            state_n = STOP;
        end
      end
      STOP: begin
        if (cnt != '0) begin
          cnt_n = cnt - 16'd1;
        end else begin
          state_n = IDLE;
          if (rxd_s) begin
            good = 1'b1;
          end else begin
            ferr  = 1'b1;
            brk_n = 1'b1;
          end
        end
      end
    endcase
  end

  // single holding register and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tvalid        <= 1'b0;
      tdata         <= '0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
    end else begin
      frame_error   <= ferr;
      overrun_error <= good && !load;
      if (tvalid && m_axis.tready)
        tvalid <= 1'b0;
      if (load) begin
        tvalid <= 1'b1;
        tdata  <= sh;
      end
    end
  end

  // quiet-line timer; one idle pulse per armed burst
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
      armed <= 1'b0;
      idle  <= 1'b0;
    end else begin
      idle <= 1'b0;
      if (state == IDLE && rxd_s) begin
        if (timer != '1)
          timer <= timer + 1'b1;
      end else begin
        timer <= '0;
      end
      if (load) begin
        armed <= 1'b1;
      end else if (armed && timer == thr) begin
        idle  <= 1'b1;
        armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_idle.sv
// Directed bench for uart_rx_idle.
// One task per scenario, inline checks.
module tb_uart_rx_idle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rxd = 1'b1;
  logic [15:0] prescale = 16'd16;
  logic        idle, busy, frame_error, overrun_error;

  taxi_axis_if #(.DATA_W(8)) axis ();

  uart_rx_idle #(.IDLE_BITS(10), .CNT_W(24)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis        (axis),
    .idle          (idle),
    .busy          (busy),
    .frame_error   (frame_error),
    .overrun_error (overrun_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int beats, idle_cnt, fe_cnt, oe_cnt, busy_rise;
  int beat_cyc, idle_cyc;
  logic [7:0] last_data;
  logic last_tlast;
  logic prev_busy = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (axis.tvalid && axis.tready) begin
        beats++;
        last_data  = axis.tdata;
        last_tlast = axis.tlast;
        beat_cyc   = cyc;
      end
      if (idle) begin
        idle_cnt++;
        idle_cyc = cyc;
      end
      if (frame_error) fe_cnt++;
      if (overrun_error) oe_cnt++;
      if (busy && !prev_busy) busy_rise++;
    end
    prev_busy = busy;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    beats = 0; idle_cnt = 0; fe_cnt = 0;
    oe_cnt = 0; busy_rise = 0;
    beat_cyc = 0; idle_cyc = 0;
    last_data = 8'h00; last_tlast = 1'b1;
  endtask

  task automatic send_byte(
    input logic [7:0] b,
    input int n,
    input logic stop
  );
    rxd = 1'b0;
    step(n);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      step(n);
    end
    rxd = stop;
    step(n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rxd = 1'b1;
    axis.tready = 1'b0; prescale = 16'd16;
    step(5);
    total++;
    if (axis.tvalid !== 1'b0) begin
      bad++; $display("FAIL rst_tvalid got=%b exp=0", axis.tvalid);
    end
    total++;
    if (axis.tdata !== 8'h00) begin
      bad++; $display("FAIL rst_tdata got=%h exp=00", axis.tdata);
    end
    total++;
    if ({idle, busy, frame_error, overrun_error} !== 4'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b exp=0000",
        {idle, busy, frame_error, overrun_error});
    end
    total++;
    if ({axis.tkeep, axis.tlast} !== 2'b10) begin
      bad++;
      $display("FAIL rst_keep_last got=%b exp=10",
        {axis.tkeep, axis.tlast});
    end
    rst_n = 1'b1;
    step(5);
  endtask

  task automatic test_single_byte();
    clr();
    prescale = 16'd16; axis.tready = 1'b1;
    send_byte(8'hA5, 16, 1'b1);
    rxd = 1'b1;
    step(220);
    total++;
    if (beats !== 1) begin
      bad++; $display("FAIL single_beats got=%0d exp=1", beats);
    end
    total++;
    if (last_data !== 8'hA5) begin
      bad++; $display("FAIL single_data got=%h exp=a5", last_data);
    end
    total++;
    if (last_tlast !== 1'b0) begin
      bad++; $display("FAIL single_tlast got=%b exp=0", last_tlast);
    end
    total++;
    if (idle_cnt !== 1) begin
      bad++; $display("FAIL single_idle got=%0d exp=1", idle_cnt);
    end
    total++;
    if (idle_cyc - beat_cyc !== 161) begin
      bad++;
      $display("FAIL single_idle_lat got=%0d exp=161",
        idle_cyc - beat_cyc);
    end
    total++;
    if (fe_cnt + oe_cnt !== 0) begin
      bad++; $display("FAIL single_errs got=%0d exp=0", fe_cnt + oe_cnt);
    end
  endtask

  task automatic test_back_to_back();
    clr();
    prescale = 16'd16; axis.tready = 1'b0;
    send_byte(8'h01, 16, 1'b1);
    send_byte(8'h02, 16, 1'b1);
    send_byte(8'h03, 16, 1'b1);
    rxd = 1'b1;
    total++;
    if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h01) begin
      bad++;
      $display("FAIL b2b_held got=%b/%h exp=1/01",
        axis.tvalid, axis.tdata);
    end
    axis.tready = 1'b1;
    step(220);
    total++;
    if (beats !== 1 || last_data !== 8'h01) begin
      bad++;
      $display("FAIL b2b_beat got=%0d/%h exp=1/01", beats, last_data);
    end
    total++;
    if (oe_cnt !== 2) begin
      bad++; $display("FAIL b2b_overrun got=%0d exp=2", oe_cnt);
    end
    total++;
    if (idle_cnt !== 1) begin
      bad++; $display("FAIL b2b_idle got=%0d exp=1", idle_cnt);
    end
    total++;
    if (fe_cnt !== 0) begin
      bad++; $display("FAIL b2b_frame got=%0d exp=0", fe_cnt);
    end
  endtask

  task automatic test_frame_error();
    int rises;
    clr();
    prescale = 16'd16; axis.tready = 1'b1;
    send_byte(8'h55, 16, 1'b0);
    rises = busy_rise;
    step(640);
    total++;
    if (busy_rise !== rises || busy !== 1'b0) begin
      bad++;
      $display("FAIL ferr_break got=%0d/%b exp=%0d/0",
        busy_rise, busy, rises);
    end
    rxd = 1'b1;
    step(220);
    total++;
    if (fe_cnt !== 1) begin
      bad++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt);
    end
    total++;
    if (beats !== 0 || idle_cnt !== 0) begin
      bad++;
      $display("FAIL ferr_quiet got=%0d/%0d exp=0/0", beats, idle_cnt);
    end
  endtask

  task automatic test_false_start();
    clr();
    prescale = 16'd16; axis.tready = 1'b1;
    rxd = 1'b0;
    step(3);
    rxd = 1'b1;
    step(100);
    total++;
    if (busy_rise !== 1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL false_busy got=%0d/%b exp=1/0", busy_rise, busy);
    end
    total++;
    if (beats + fe_cnt + oe_cnt + idle_cnt !== 0) begin
      bad++;
      $display("FAIL false_quiet got=%0d exp=0",
        beats + fe_cnt + oe_cnt + idle_cnt);
    end
  endtask

  task automatic test_prescale_clamp();
    clr();
    prescale = 16'd2; axis.tready = 1'b1;
    send_byte(8'h3C, 4, 1'b1);
    rxd = 1'b1;
    step(80);
    total++;
    if (beats !== 1 || last_data !== 8'h3C) begin
      bad++;
      $display("FAIL clamp_beat got=%0d/%h exp=1/3c", beats, last_data);
    end
    total++;
    if (idle_cnt !== 1 || idle_cyc - beat_cyc !== 41) begin
      bad++;
      $display("FAIL clamp_idle got=%0d/%0d exp=1/41",
        idle_cnt, idle_cyc - beat_cyc);
    end
    total++;
    if (fe_cnt + oe_cnt !== 0) begin
      bad++; $display("FAIL clamp_errs got=%0d exp=0", fe_cnt + oe_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] part;
    part = 8'hF0;
    clr();
    prescale = 16'd16; axis.tready = 1'b0;
    send_byte(8'h81, 16, 1'b1);
    rxd = 1'b1;
    step(20);
    rxd = 1'b0;
    step(16);
    for (int i = 0; i < 4; i++) begin
      rxd = part[i];
      step(16);
    end
    rxd = part[4];
    step(8);
    rst_n = 1'b0;
    rxd = 1'b1;
    #1;
    total++;
    if ({axis.tvalid, busy, idle, frame_error, overrun_error}
        !== 5'b0) begin
      bad++;
      $display("FAIL rmid_flags got=%b exp=00000",
        {axis.tvalid, busy, idle, frame_error, overrun_error});
    end
    total++;
    if (axis.tdata !== 8'h00) begin
      bad++; $display("FAIL rmid_tdata got=%h exp=00", axis.tdata);
    end
    step(3);
    rst_n = 1'b1;
    axis.tready = 1'b1;
    clr();
    step(250);
    total++;
    if (idle_cnt !== 0 || beats !== 0) begin
      bad++;
      $display("FAIL rmid_stale got=%0d/%0d exp=0/0", idle_cnt, beats);
    end
    send_byte(8'hC3, 16, 1'b1);
    rxd = 1'b1;
    step(220);
    total++;
    if (beats !== 1 || last_data !== 8'hC3) begin
      bad++;
      $display("FAIL rmid_beat got=%0d/%h exp=1/c3", beats, last_data);
    end
    total++;
    if (idle_cnt !== 1 || fe_cnt + oe_cnt !== 0) begin
      bad++;
      $display("FAIL rmid_after got=%0d/%0d exp=1/0",
        idle_cnt, fe_cnt + oe_cnt);
    end
  endtask

  initial begin
    axis.tready = 1'b0;
    clr();
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_frame_error();
    test_false_start();
    test_prescale_clamp();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_idle.md
# uart_rx_idle

UART receiver with idle-line detection, the 8-bit source stage directly upstream of the AES register bridge. Deserialises the RX pin into bytes on an AXI-Stream source, and emits a one-cycle `idle` pulse once the line has been quiet long enough after a burst. The bridge uses `idle` to close a partial 128-bit block in encrypt-on-receive mode. Framing and overrun errors are flagged, and the bad byte is dropped.

## Interface
- `IDLE_BITS`, default 10: quiet-line length, in bit periods, that ends a burst.
- `CNT_W`, default 24: width of the idle timer; the timer saturates.
- `clk` in, 1: single clock domain.
- `rst_n` in, 1: asynchronous, active-low reset.
- `rxd` in, 1: asynchronous serial input; idles high.
- `prescale` in, 16: clock cycles per bit. Values below 4 are treated as 4. Sampled at start-bit detection.
- `m_axis` `taxi_axis_if.src`, 8-bit `tdata`: received bytes. `tkeep`=1 and `tlast`=0 always.
- `idle` out, 1: one-cycle pulse at the end of a burst.
- `busy` out, 1: high from start-bit detection until the stop-bit sample.
- `frame_error` out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun_error` out, 1: one-cycle pulse when a completed byte is dropped because the output is full.

## Operation
- **Input synchronisation:** `rxd` passes through a 2-flop synchroniser (reset to 1), giving `rxd_s`. All logic below uses `rxd_s`.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE → START:** on `rxd_s`=0. Latch `p = max(prescale, 4)`. Load the bit counter with `p/2` (floor).
- **START:** on counter expiry, sample `rxd_s`.
  - 1: false start → IDLE, no flags.
  - 0: → DATA. Reload the counter with `p`. Clear the bit index.
- **DATA:** on each expiry, shift `rxd_s` into the shift register, LSB first. Reload `p`. After 8 samples → STOP.
- **STOP:** on expiry, sample `rxd_s`.
  - 1: byte is good. Hand it to the output register.
  - 0: pulse `frame_error`, discard the byte, and wait in IDLE until `rxd_s` returns to 1 before accepting a new start (break handling).
- **Output register:**
  - A single holding register, with `tvalid` cleared on `tvalid && tready`.
  - A good byte arriving while `tvalid`=1 and `tready`=0 is dropped, `overrun_error` pulses, and the held byte is kept.
  - A good byte arriving in the same cycle as a handshake on the held byte is accepted with no error.
- **Idle timer:**
  - Counts clocks while the FSM is in IDLE and `rxd_s`=1. Cleared by any `rxd_s`=0 and whenever the FSM is not in IDLE. Saturates at all-ones.
  - An `armed` flag is set when a good byte is loaded into the output register.
  - When the timer equals `IDLE_BITS*p` (CNT_W-bit product, `p` as last latched) and `armed`=1: pulse `idle` and clear `armed`.
  - At most one `idle` per burst. No `idle` without a preceding good byte.
- **Reset, whether at power-up or asserted mid-frame:** FSM → IDLE; partial byte discarded; held byte discarded; `armed`=0; timer=0; latched `p`=4.

## Timing
- **Reset values:**
  - 0: `tvalid`, `tdata`, `idle`, `busy`, `frame_error`, `overrun_error`.
  - 1: `tkeep`. 0: `tlast`.
- **Start detection:** 2 cycles of synchroniser latency from the `rxd` edge to `rxd_s`. START is entered the cycle after `rxd_s` falls.
- **Sample points:**
  - START sample: `p/2` cycles after START is entered.
  - Each later sample: `p` cycles after the previous one.
- **Byte latency:** `tvalid` rises 1 cycle after the stop-bit sample.
- **Error pulses:** `frame_error` and `overrun_error` assert 1 cycle after the stop-bit sample.
- **Idle latency:** `idle` asserts the cycle after the timer reaches `IDLE_BITS*p`.
  - The timer starts counting on the first IDLE cycle after STOP.
- **Back-to-back frames:** a new start bit is accepted in the cycle immediately following the stop sample.

## Structure
- **Package `uart_rx_pkg`:**
  - `uart_rx_state_t` enum {IDLE, START, DATA, STOP}.
  - `UART_MIN_PRESCALE` = 4.
  - `UART_DATA_BITS` = 8.
- **Sub-module `uart_rx_sync`:** 2-flop synchroniser with a reset value parameter.
- **Top module:** contains the FSM, the output register and the idle timer.

## Test plan
- **Single byte:** `prescale`=16, send 0xA5 with a good stop bit, `tready`=1 → one beat with `tdata`=0xA5 and `tlast`=0. Then `idle` pulses exactly once, 160 cycles of high line later.
- **Burst with backpressure:** send 3 bytes back-to-back (0x01, 0x02, 0x03) with `tready`=0 until the third byte's stop bit → 0x01 held, `overrun_error` pulses twice, `idle` fires once after the burst.
- **Framing error and break:** stop bit low on 0x55, `rxd` held low for 40 bit times → `frame_error` pulses once, no beat, no `idle`, no new start until `rxd` goes high.
- **False start:** a 3-cycle low glitch at `prescale`=16 → FSM returns to IDLE, no flags, no beat, `busy` pulses briefly.
- **Prescale clamp:** `prescale`=2, byte 0x3C at 4 clocks per bit → received correctly.
- **Reset mid-frame:** assert `rst_n` during DATA bit 4 → all outputs 0. A following byte 0xC3 is received cleanly and there is no stale `idle`.
